// File: rtl/score_disp.sv
// Seven-segment score driver: serial binary-to-BCD (double dabble) or direct hex,
// registered segment output with leading-zero blanking, overflow dashes and blink.
//
// state  | meaning
// IDLE   | waiting for load; display holds last committed value
// SHIFT  | shifting one value bit per cycle into the BCD accumulator
// COMMIT | writing digits and ovf into the display register
module score_disp #(
    parameter int DIGITS    = 2,
    parameter int VAL_W     = 7,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VAL_W-1:0]      value,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    output logic                  busy,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   light
);
    localparam int AW = 4*DIGITS + 4;
    localparam int DW = 4*DIGITS;
    localparam int LW = 7*DIGITS;
    localparam int CW = $clog2(VAL_W + 1);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_INIT   = CW'(VAL_W - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [31:0]   MAX_DEC    = 32'(10**DIGITS - 1);
    localparam logic [31:0]   HEX_LIM    = 32'(16**DIGITS);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [VAL_W-1:0]   val_q, val_d;
    logic [VAL_W-1:0]   sh_q, sh_d;
    logic               hex_q, hex_d;
    logic [AW-1:0]      acc_q, acc_d, acc_adj;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]      disp_q, disp_d;
    logic               ovf_q, ovf_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic               phase_q, phase_d;
    logic [LW-1:0]      light_q, light_d;
    logic [DW+VAL_W-1:0] hex_ext;
    logic               unused_bits;

    function automatic logic [AW-1:0] add3(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = a;
        for (int n = 0; n < DIGITS + 1; n++) begin
            if (a[4*n +: 4] >= 4'd5) r[4*n +: 4] = a[4*n +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign hex_ext     = {{DW{1'b0}}, val_q};
    assign unused_bits = ^{acc_adj[AW-1], hex_ext[DW +: VAL_W]};

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        sh_d    = sh_q;
        hex_d   = hex_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        acc_adj = add3(acc_q);
        case (state_q)
            IDLE: begin
                if (load) begin
                    val_d   = value;
                    sh_d    = value;
                    hex_d   = hex_mode;
                    acc_d   = '0;
                    cnt_d   = CNT_INIT;
                    state_d = hex_mode ? COMMIT : SHIFT;
                end
            end
            SHIFT: begin
                acc_d = {acc_adj[AW-2:0], sh_q[VAL_W-1]};
                sh_d  = sh_q << 1;
                if (cnt_q == '0) state_d = COMMIT;
                else             cnt_d   = cnt_q - CW'(1);
            end
            COMMIT: begin
                // ovf is judged on the raw value so an oversized input can never alias
                if (hex_q) begin
                    disp_d = hex_ext[DW-1:0];
                    ovf_d  = 32'(val_q) >= HEX_LIM;
                end else begin
                    disp_d = acc_q[DW-1:0];
                    ovf_d  = 32'(val_q) > MAX_DEC;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bcnt_d  = '0;
        phase_d = 1'b0;
        if (blink_en) begin
            phase_d = phase_q;
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    always_comb begin
        logic       hi_zero;
        logic [3:0] dig;
        logic [6:0] seg;
        light_d = '1;
        hi_zero = 1'b1;
        dig     = '0;
        seg     = '1;
        // walk from the top digit down so hi_zero covers this digit and all above
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig     = disp_q[4*i +: 4];
            hi_zero = hi_zero & (dig == 4'd0);
            if (phase_q)                          seg = 7'b1111111;
            else if (ovf_q)                       seg = 7'b0111111;
            else if (blank_lz && i > 0 && hi_zero) seg = 7'b1111111;
            else                                  seg = seg7(dig);
            light_d[7*i +: 7] = seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            val_q   <= '0;
            sh_q    <= '0;
            hex_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            light_q <= '1;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            sh_q    <= sh_d;
            hex_q   <= hex_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            light_q <= light_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign ovf   = ovf_q;
    assign light = light_q;
endmodule

// File: tb/tb_score_disp.sv
// Bench for score_disp: arithmetic display model checked every cycle, plus literal
// expectations; a one-digit instance covers hex overflow.
module tb_score_disp;
    localparam int BD = 4;

    logic        clk = 1'b0;
    logic        reset, load, hex_mode, blank_lz, blink_en;
    logic [6:0]  value;
    logic        busy, ovf, busy1, ovf1;
    logic [13:0] light;
    logic [6:0]  light1;

    int n_cmp = 0;
    int n_err = 0;

    score_disp #(.DIGITS(2), .VAL_W(7), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .blink_en(blink_en), .busy(busy), .ovf(ovf), .light(light));

    score_disp #(.DIGITS(1), .VAL_W(7), .BLINK_DIV(BD)) dut1 (
        .clk(clk), .reset(reset), .value(value), .load(load), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .blink_en(blink_en), .busy(busy1), .ovf(ovf1), .light(light1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9: return 7'b0010000;  10: return 7'b0001000; 11: return 7'b0000011;
            12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [13:0] model_light(input int v, input bit hx, input bit ov,
                                                input bit blz, input bit ph);
        logic [13:0] r;
        int base, pw;
        base = hx ? 16 : 10;
        r = '1;
        for (int i = 0; i < 2; i++) begin
            pw = (i == 0) ? 1 : base;
            if (ph)                          r[7*i +: 7] = 7'b1111111;
            else if (ov)                     r[7*i +: 7] = 7'b0111111;
            else if (blz && i > 0 && v < pw) r[7*i +: 7] = 7'b1111111;
            else                             r[7*i +: 7] = seg_of((v / pw) % base);
        end
        return r;
    endfunction

    // Model: committed value, pending conversion countdown, length of current blink run
    int          m_val, p_val, m_busy, m_run;
    bit          m_hex, p_hex, m_ovf, model_ok = 1'b0;
    logic [13:0] exp_light;

    always @(posedge clk) begin
        if (reset) begin
            exp_light = '1;
            m_busy = 0; m_val = 0; m_hex = 0; m_ovf = 0; m_run = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            exp_light = model_light(m_val, m_hex, m_ovf, blank_lz, ((m_run / BD) % 2) == 1);
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_val = p_val;
                    m_hex = p_hex;
                    m_ovf = p_hex ? (p_val >= 256) : (p_val > 99);
                end
            end else if (load) begin
                p_val  = int'(value);
                p_hex  = hex_mode;
                m_busy = hex_mode ? 1 : 8;
            end
            m_run = blink_en ? m_run + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_light", 32'(light), 32'(exp_light));
            chk("model_busy", 32'(busy), 32'(m_busy > 0));
            chk("model_ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    // Pulse load at a negedge, count busy cycles, return after the light-update edge.
    task automatic convert(input logic [6:0] v, input logic hx, output int nb);
        @(negedge clk);
        value = v; hex_mode = hx; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        nb = 0;
        while (busy && nb < 50) begin
            nb++;
            @(negedge clk);
        end
        if (nb >= 50) chk("busy_timeout", 32'(nb), 32'd0);
        @(negedge clk);
    endtask

    typedef struct { logic [6:0] v; logic hx; logic blz; } vec_t;
    vec_t vecs[9] = '{'{7'd0, 1'b0, 1'b1}, '{7'd9, 1'b0, 1'b1}, '{7'd10, 1'b0, 1'b1},
                      '{7'd99, 1'b0, 1'b0}, '{7'd100, 1'b0, 1'b0}, '{7'd127, 1'b1, 1'b1},
                      '{7'd10, 1'b1, 1'b1}, '{7'd0, 1'b1, 1'b1}, '{7'd64, 1'b0, 1'b1}};

    localparam logic [13:0] L42   = {7'b0011001, 7'b0100100};
    localparam logic [13:0] L00   = {7'b1000000, 7'b1000000};
    localparam logic [13:0] LDASH = {7'b0111111, 7'b0111111};

    initial begin
        int nb;
        reset = 1'b1; load = 1'b0; hex_mode = 1'b0; blank_lz = 1'b0; blink_en = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        chk("reset_light", 32'(light), 32'h3FFF);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_light", 32'(light), 32'(L00));
        chk("post_reset_light1", 32'(light1), 32'(7'b1000000));

        convert(7'd42, 1'b0, nb);
        chk("dec42_busy_cycles", 32'(nb), 32'd8);
        chk("dec42_light", 32'(light), 32'(L42));
        chk("dec42_ovf", 32'(ovf), 32'd0);

        convert(7'd123, 1'b0, nb);
        chk("dec123_ovf", 32'(ovf), 32'd1);
        chk("dec123_light", 32'(light), 32'(LDASH));

        blank_lz = 1'b1;
        convert(7'd7, 1'b0, nb);
        chk("dec7_ovf", 32'(ovf), 32'd0);
        chk("dec7_lz_light", 32'(light), 32'({7'b1111111, 7'b1111000}));
        convert(7'd10, 1'b0, nb);
        chk("dec10_lz_light", 32'(light), 32'({7'b1111001, 7'b1000000}));
        convert(7'h0A, 1'b1, nb);
        chk("hex0A_lz_light", 32'(light), 32'({7'b1111111, 7'b0001000}));
        blank_lz = 1'b0;

        convert(7'h5A, 1'b1, nb);
        chk("hex5A_busy_cycles", 32'(nb), 32'd1);
        chk("hex5A_light", 32'(light), 32'({7'b0010010, 7'b0001000}));
        convert(7'h1F, 1'b1, nb);
        chk("hex1F_light", 32'(light), 32'({7'b1111001, 7'b0001110}));
        chk("hex1F_d1_ovf", 32'(ovf1), 32'd1);
        chk("hex1F_d1_light", 32'(light1), 32'(7'b0111111));
        convert(7'h0F, 1'b1, nb);
        chk("hex0F_d1_ovf", 32'(ovf1), 32'd0);
        chk("hex0F_d1_light", 32'(light1), 32'(7'b0001110));
        chk("hex0F_d1_busy", 32'(busy1), 32'd0);

        foreach (vecs[j]) begin
            blank_lz = vecs[j].blz;
            convert(vecs[j].v, vecs[j].hx, nb);
        end
        blank_lz = 1'b0;

        convert(7'd42, 1'b0, nb);
        @(negedge clk);
        blink_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("blink_pattern", 32'(light), ((i / BD) % 2 == 1) ? 32'h3FFF : 32'(L42));
        end
        blink_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("blink_off_light", 32'(light), 32'(L42));

        // load while busy is dropped
        convert(7'd5, 1'b0, nb);
        @(negedge clk);
        value = 7'd42; hex_mode = 1'b0; load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk);
        @(negedge clk); value = 7'd99; load = 1'b1;
        @(negedge clk); load = 1'b0;
        nb = 0;
        while (busy && nb < 50) begin nb++; @(negedge clk); end
        if (nb >= 50) chk("busy_timeout", 32'(nb), 32'd0);
        @(negedge clk);
        chk("ignored_load_light", 32'(light), 32'(L42));

        // load held high restarts each time IDLE is re-entered
        @(negedge clk);
        value = 7'd13; load = 1'b1;
        repeat (25) @(negedge clk);
        load = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_load_light", 32'(light), 32'({7'b1111001, 7'b0110000}));

        // reset aborts a conversion and discards the display
        convert(7'd42, 1'b0, nb);
        @(negedge clk);
        value = 7'd77; load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_light", 32'(light), 32'h3FFF);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_after_light", 32'(light), 32'(L00));
        chk("midreset_after_ovf", 32'(ovf), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
